// File: rtl/vec_frame_loader.sv
// vec_frame_loader: packs a stream of WORD_W-bit words into a WORDS-slot frame plus a scalar operand
// and hands it off over valid/ready. Define VEC_FRAME_LOADER_DBUF_EN for ping-pong double buffering.
module vec_frame_loader #(
  parameter int WORDS  = 16,
  parameter int WORD_W = 64,
  parameter int OP_W   = 32,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WORD_W-1:0]       in_word,
  input  logic                    in_last,
  input  logic [OP_W-1:0]         in_op,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WORDS*WORD_W-1:0] out_vec,
  output logic [OP_W-1:0]         out_op,
  output logic                    short_err,
  output logic [CNT_W-1:0]        frame_cnt
);
  localparam int               IDX_W    = $clog2(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
  localparam logic [0:0]       FILL     = 1'b0;
  localparam logic [0:0]       FULL     = 1'b1;
`ifdef VEC_FRAME_LOADER_DBUF_EN
  localparam logic PINGPONG = 1'b1;
`else
  localparam logic PINGPONG = 1'b0;
`endif

  // Two banks are always declared; without ping-pong the select never leaves bank 0,
  // so bank 1 stays in reset and is optimised away.
  logic [0:0]        bank_state [2];
  logic [WORD_W-1:0] slots      [2][WORDS];
  logic [OP_W-1:0]   ops        [2];
  logic [IDX_W-1:0]  idx;
  logic              wr_sel;
  logic              rd_sel;

  logic       beat;
  logic       close;
  logic       hs;
  logic       wr_sel_nxt;
  logic       rd_sel_nxt;
  logic [1:0] full_nxt;

  always_comb begin
    // NOTE: every signal written here gets a value before any condition, so no latch can be inferred.
    full_nxt   = '0;
    beat       = in_valid & in_ready;
    close      = beat & (in_last | (idx == LAST_IDX));
    hs         = out_valid & out_ready;
    wr_sel_nxt = close ? (wr_sel ^ PINGPONG) : wr_sel;
    rd_sel_nxt = hs ? (rd_sel ^ PINGPONG) : rd_sel;
    for (int b = 0; b < 2; b++) begin
      full_nxt[b] = ((bank_state[b] == FULL) & ~(hs & (rd_sel == 1'(b))))
                  | (close & (wr_sel == 1'(b)));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the frame store is reset on purpose: out_vec must read zero during reset and
      // the slots past an early in_last rely on starting from zero.
      for (int b = 0; b < 2; b++) begin
        bank_state[b] <= FILL;
        ops[b]        <= '0;
        for (int k = 0; k < WORDS; k++) slots[b][k] <= '0;
      end
      idx       <= '0;
      wr_sel    <= 1'b0;
      rd_sel    <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      short_err <= 1'b0;
      frame_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every term above sees pre-edge state.
      if (hs) begin
        for (int k = 0; k < WORDS; k++) slots[rd_sel][k] <= '0;
        frame_cnt <= frame_cnt + 1'b1;
      end
      if (beat) begin
        slots[wr_sel][idx] <= in_word;
        idx                <= close ? '0 : idx + 1'b1;
      end
      if (close) ops[wr_sel] <= in_op;
      for (int b = 0; b < 2; b++) bank_state[b] <= full_nxt[b] ? FULL : FILL;
      wr_sel    <= wr_sel_nxt;
      rd_sel    <= rd_sel_nxt;
      in_ready  <= ~full_nxt[wr_sel_nxt];
      out_valid <= full_nxt[rd_sel_nxt];
      // in_last on the final slot is an ordinary full frame, not an early close.
      short_err <= beat & in_last & (idx != LAST_IDX);
    end
  end

  always_comb begin
    out_vec = '0;
    for (int k = 0; k < WORDS; k++) begin
      out_vec[WORDS*WORD_W-1-k*WORD_W -: WORD_W] = slots[rd_sel][k];
    end
  end

  assign out_op = ops[rd_sel];

endmodule

// File: tb/tb_vec_frame_loader.sv
// tb_vec_frame_loader: table-driven directed frames, hand sequences for reset/wrap/no-last,
// and a randomized phase, all checked against a queue-based frame model.
module tb_vec_frame_loader;
  localparam int WORDS  = 16;
  localparam int WORD_W = 64;
  localparam int OP_W   = 32;
  localparam int VW     = WORDS * WORD_W;
`ifdef VEC_FRAME_LOADER_DBUF_EN
  localparam int BANKS = 2;
`else
  localparam int BANKS = 1;
`endif

  typedef struct {
    logic [VW-1:0]   vec;
    logic [OP_W-1:0] op;
  } frame_t;

  typedef struct {
    int          n;
    bit          with_last;
    logic [63:0] base;
    logic [63:0] inc;
    logic [31:0] op;
    int          stall;
    logic [63:0] exp_first;
    logic [63:0] exp_lastw;
    int          exp_short;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_last = 1'b0;
  logic              out_ready = 1'b0;
  logic [WORD_W-1:0] in_word = '0;
  logic [OP_W-1:0]   in_op = '0;

  logic              in_ready, out_valid, short_err;
  logic [VW-1:0]     out_vec;
  logic [OP_W-1:0]   out_op;
  logic [15:0]       frame_cnt;
  logic              in_ready_w, out_valid_w, short_err_w;
  logic [VW-1:0]     out_vec_w;
  logic [OP_W-1:0]   out_op_w;
  logic [1:0]        frame_cnt_w;

  always #5 clk = ~clk;

  vec_frame_loader dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
    .in_last(in_last), .in_op(in_op), .out_valid(out_valid), .out_ready(out_ready),
    .out_vec(out_vec), .out_op(out_op), .short_err(short_err), .frame_cnt(frame_cnt)
  );

  vec_frame_loader #(.CNT_W(2)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w), .in_word(in_word),
    .in_last(in_last), .in_op(in_op), .out_valid(out_valid_w), .out_ready(out_ready),
    .out_vec(out_vec_w), .out_op(out_op_w), .short_err(short_err_w), .frame_cnt(frame_cnt_w)
  );

  // Reference model: words of the frame being filled, frames waiting for handoff.
  logic [WORD_W-1:0] fill_q [$];
  frame_t            pend_q [$];
  bit                m_ready;
  bit                m_err;
  int unsigned       m_cnt;

  frame_t got_q [$];
  frame_t snap;
  bit     snap_valid;
  int     err_seen;
  int     n_tests = 0;
  int     n_fail  = 0;

  function automatic logic [63:0] slot(input logic [VW-1:0] v, input int k);
    return v[VW-1-k*WORD_W -: WORD_W];
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    int k;
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      k = 0;
      while (k < WORDS - 1 && slot(got, k) === slot(exp, k)) k++;
      $display("FAIL %s: slot %0d got %h, required %h", name, k, slot(got, k), slot(exp, k));
    end
  endtask

  function automatic void model_reset();
    fill_q.delete();
    pend_q.delete();
    got_q.delete();
    m_ready    = 1'b0;
    m_err      = 1'b0;
    m_cnt      = 0;
    snap_valid = 1'b0;
    err_seen   = 0;
  endfunction

  function automatic void model_tick();
    bit     beat;
    bit     hs;
    frame_t f;
    beat  = in_valid && m_ready;
    hs    = (pend_q.size() > 0) && out_ready;
    m_err = 1'b0;
    if (hs) begin
      void'(pend_q.pop_front());
      m_cnt++;
    end
    if (beat) begin
      fill_q.push_back(in_word);
      if (in_last || fill_q.size() == WORDS) begin
        f.vec = '0;
        foreach (fill_q[k]) f.vec[VW-1-k*WORD_W -: WORD_W] = fill_q[k];
        f.op  = in_op;
        pend_q.push_back(f);
        m_err = fill_q.size() < WORDS;
        fill_q.delete();
      end
    end
    m_ready = pend_q.size() < BANKS;
  endfunction

  task automatic compare_all();
    bit mv;
    mv = pend_q.size() > 0;
    check("in_ready", in_ready, m_ready);
    check("out_valid", out_valid, mv);
    check("short_err", short_err, m_err);
    check("frame_cnt", frame_cnt, m_cnt[15:0]);
    check("in_ready_w", in_ready_w, m_ready);
    check("out_valid_w", out_valid_w, mv);
    check("short_err_w", short_err_w, m_err);
    check("frame_cnt_w", frame_cnt_w, m_cnt[1:0]);
    if (mv) begin
      check_vec("out_vec", out_vec, pend_q[0].vec);
      check("out_op", out_op, pend_q[0].op);
      check_vec("out_vec_w", out_vec_w, pend_q[0].vec);
      check("out_op_w", out_op_w, pend_q[0].op);
    end
    if (short_err) err_seen++;
    snap_valid = out_valid;
    snap.vec   = out_vec;
    snap.op    = out_op;
  endtask

  // One clock: record a handoff seen by the DUT, advance the model, compare on the falling edge.
  task automatic step();
    @(posedge clk);
    if (snap_valid && out_ready) got_q.push_back(snap);
    model_tick();
    @(negedge clk);
    compare_all();
  endtask

  task automatic check_reset_outputs();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check_vec("rst_out_vec", out_vec, '0);
    check("rst_out_op", out_op, 0);
    check("rst_short_err", short_err, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_frame_cnt_w", frame_cnt_w, 0);
  endtask

  // Asserts rst between clock edges and checks outputs before any edge occurs.
  task automatic apply_reset();
    #2 rst = 1'b0;
    #1 check_reset_outputs();
    model_reset();
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic send_word(input logic [63:0] w, input bit last, input logic [31:0] op);
    bit acc;
    int guard;
    acc   = 1'b0;
    guard = 0;
    in_valid = 1'b1;
    in_word  = w;
    in_last  = last;
    in_op    = op;
    while (!acc && guard < 100) begin
      acc = m_ready;
      step();
      guard++;
    end
    check("accept_bound", acc, 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_handoff();
    int guard;
    guard = 0;
    while (got_q.size() == 0 && guard < 100) begin
      step();
      guard++;
    end
    check("handoff_bound", got_q.size() > 0, 1);
  endtask

  vec_t        tbl [5];
  vec_t        t;
  frame_t      fr;
  int          e0;
  int          stall_acc;
  int          cnt_exp;
  bit          tz;
  logic [1:0]  exp_seq [5];

  initial begin
    tbl[0] = '{16, 1'b1, 64'h1,    64'h1,  32'hA5,    0,  64'h1,    64'h10,   0};
    tbl[1] = '{3,  1'b1, 64'hAA,   64'h11, 32'h7,     0,  64'hAA,   64'hCC,   1};
    tbl[2] = '{16, 1'b1, 64'h100,  64'h1,  32'h5A5A,  10, 64'h100,  64'h10F,  0};
    tbl[3] = '{1,  1'b1, 64'hDEAD, 64'h0,  32'h1,     2,  64'hDEAD, 64'hDEAD, 1};
    tbl[4] = '{16, 1'b0, 64'h200,  64'h1,  32'h33,    0,  64'h200,  64'h20F,  0};
    exp_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    apply_reset();
    cnt_exp = 0;
    foreach (tbl[i]) begin
      t  = tbl[i];
      e0 = err_seen;
      out_ready = (t.stall == 0);
      for (int k = 0; k < t.n; k++) send_word(t.base + t.inc * k, t.with_last && (k == t.n - 1), t.op);
      in_valid  = (BANKS == 1);
      in_word   = 64'hBAD0_BAD0_BAD0_BAD0;
      stall_acc = 0;
      for (int s = 0; s < t.stall; s++) begin
        if (in_valid && in_ready) stall_acc++;
        step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      wait_handoff();
      cnt_exp++;
      if (got_q.size() > 0) begin
        fr = got_q.pop_front();
        check("tbl_slot_first", slot(fr.vec, 0), t.exp_first);
        check("tbl_slot_last", slot(fr.vec, t.n - 1), t.exp_lastw);
        tz = 1'b1;
        for (int k = t.n; k < WORDS; k++) if (slot(fr.vec, k) != 0) tz = 1'b0;
        check("tbl_tail_zero", tz, 1);
        check("tbl_op", fr.op, t.op);
      end
      check("tbl_short_pulses", err_seen - e0, t.exp_short);
      check("tbl_stall_accept", stall_acc, 0);
      check("tbl_frame_cnt", frame_cnt, cnt_exp);
    end

    // Reset mid-frame: leftover words must not appear in the next frame.
    for (int k = 0; k < 5; k++) send_word(64'hF00 + k, 1'b0, 32'h9);
    apply_reset();
    step();
    check("mid_rst_no_err", err_seen, 0);
    send_word(64'h41, 1'b0, 32'h0);
    send_word(64'h42, 1'b1, 32'h77);
    wait_handoff();
    if (got_q.size() > 0) begin
      fr = got_q.pop_front();
      check("mid_rst_slot0", slot(fr.vec, 0), 64'h41);
      check("mid_rst_slot1", slot(fr.vec, 1), 64'h42);
      check("mid_rst_slot2", slot(fr.vec, 2), 64'h0);
      check("mid_rst_slot4", slot(fr.vec, 4), 64'h0);
      check("mid_rst_op", fr.op, 32'h77);
    end
    check("mid_rst_short", err_seen, 1);

    // Counter wrap on the 2-bit instance.
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      send_word(64'h1 + i, 1'b1, 32'(i));
      wait_handoff();
      void'(got_q.pop_front());
      check("wrap_cnt", frame_cnt_w, exp_seq[i]);
    end

    // Twenty words with no in_last, then one closing word.
    apply_reset();
    for (int k = 0; k < 20; k++) send_word(64'h300 + k, 1'b0, 32'h55);
    send_word(64'h314, 1'b1, 32'h66);
    wait_handoff();
    if (got_q.size() > 0) begin
      fr = got_q.pop_front();
      check("nolast_a_slot0", slot(fr.vec, 0), 64'h300);
      check("nolast_a_slot15", slot(fr.vec, 15), 64'h30F);
      check("nolast_a_op", fr.op, 32'h55);
    end
    wait_handoff();
    if (got_q.size() > 0) begin
      fr = got_q.pop_front();
      for (int k = 0; k < 5; k++) check("nolast_b_slot", slot(fr.vec, k), 64'h310 + k);
      check("nolast_b_slot5", slot(fr.vec, 5), 64'h0);
      check("nolast_b_op", fr.op, 32'h66);
    end
    check("nolast_short", err_seen, 1);

    // Randomized traffic with random backpressure.
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(3) != 0);
      in_word   = {$urandom, $urandom};
      in_last   = ($urandom_range(7) == 0);
      in_op     = $urandom;
      out_ready = ($urandom_range(2) != 0);
      step();
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (10) step();
    check("drain_cnt", frame_cnt, m_cnt[15:0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
